// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate extraction pipeline.
package imm_pkg;

  localparam int unsigned IMM_DATA_W_DEFAULT = 64;
  localparam int unsigned IMM_OP_W           = 5;

  typedef enum logic [IMM_OP_W-1:0] {
    IMM_NONE  = 5'b00000,
    IMM_D     = 5'b00001,
    IMM_SHIFT = 5'b00010,
    IMM_I     = 5'b00100,
    IMM_CB    = 5'b01000,
    IMM_B     = 5'b10000
  } imm_op_e;

  // Instruction bit positions of each immediate field
  localparam int unsigned B_MSB     = 25;
  localparam int unsigned B_LSB     = 0;
  localparam int unsigned CB_MSB    = 23;
  localparam int unsigned CB_LSB    = 5;
  localparam int unsigned I_MSB     = 21;
  localparam int unsigned I_LSB     = 10;
  localparam int unsigned SHIFT_MSB = 15;
  localparam int unsigned SHIFT_LSB = 10;
  localparam int unsigned D_MSB     = 20;
  localparam int unsigned D_LSB     = 12;

  // Buffer entry; imm is sized for the widest legal DATA_W
  typedef struct packed {
    logic                          err;
    logic [IMM_DATA_W_DEFAULT-1:0] imm;
  } imm_entry_t;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational immediate field extraction and sign/zero extension.
// IMM_BRANCH_SCALE_EN: when defined, B and CB results are shifted left by 2.
module imm_field_extract
  import imm_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = IMM_DATA_W_DEFAULT
) (
  input  logic [INSTR_W-1:0]  instr,
  input  logic [IMM_OP_W-1:0] imm_op,
  input  logic                zero_ext,
  output logic [DATA_W-1:0]   imm_c,
  output logic                err_c
);

  // Field [msb:lsb] of word, optionally sign-extended from its top bit
  function automatic logic [DATA_W-1:0] extend(
    input logic [INSTR_W-1:0] word,
    input int unsigned        msb,
    input int unsigned        lsb,
    input logic               sext
  );
    logic [DATA_W-1:0]  hi_mask;
    logic [DATA_W-1:0]  field;
    logic [INSTR_W-1:0] top;
    hi_mask = {DATA_W{1'b1}} << (msb - lsb + 1);
    field   = DATA_W'(word >> lsb) & ~hi_mask;
    top     = word >> msb;
    return (sext && top[0]) ? (field | hi_mask) : field;
  endfunction

  function automatic logic [DATA_W-1:0] branch_scale(input logic [DATA_W-1:0] v);
`ifdef IMM_BRANCH_SCALE_EN
    return v << 2;
`else
    return v;
`endif
  endfunction

  always_comb begin
    imm_c = '0;
    err_c = 1'b0;
    case (imm_op)
      IMM_B:     imm_c = branch_scale(extend(instr, B_MSB, B_LSB, ~zero_ext));
      IMM_CB:    imm_c = branch_scale(extend(instr, CB_MSB, CB_LSB, ~zero_ext));
      IMM_I:     imm_c = extend(instr, I_MSB, I_LSB, ~zero_ext);
      IMM_SHIFT: imm_c = extend(instr, SHIFT_MSB, SHIFT_LSB, 1'b0);
      IMM_D:     imm_c = extend(instr, D_MSB, D_LSB, ~zero_ext);
      IMM_NONE:  imm_c = '0;
      default:   err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extraction feeding a DEPTH-entry output FIFO with valid/ready on both sides.
// IMM_BRANCH_SCALE_EN (see imm_field_extract) enables left-by-2 scaling of B/CB immediates.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = IMM_DATA_W_DEFAULT,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instr,
  input  logic [IMM_OP_W-1:0]        imm_op,
  input  logic                       zero_ext,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          immediate,
  output logic                       imm_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] ext_imm_c;
  logic              ext_err_c;

  imm_field_extract #(
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W)
  ) u_extract (
    .instr    (instr),
    .imm_op   (imm_op),
    .zero_ext (zero_ext),
    .imm_c    (ext_imm_c),
    .err_c    (ext_err_c)
  );

  imm_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             push, pop;
  imm_entry_t       new_entry, head_nxt;

  // Next-state for pointers, occupancy and the registered head view
  always_comb begin
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    new_entry  = '{err: ext_err_c, imm: IMM_DATA_W_DEFAULT'(ext_imm_c)};
    wr_ptr_nxt = wr_ptr + PTR_W'(push);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    count_nxt  = count;
    head_nxt   = '0;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
    // A push landing in an otherwise-empty buffer becomes the new head
    if (count_nxt != '0) begin
      if (push && (count_nxt == CNT_W'(1))) begin
        head_nxt = new_entry;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      immediate <= '0;
      imm_err   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      in_ready  <= (32'(count_nxt) < DEPTH);
      out_valid <= (count_nxt != '0);
      immediate <= DATA_W'(head_nxt.imm);
      imm_err   <= head_nxt.err;
    end
  end

  // Storage array; stale contents are ignored once count is cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed spec vectors plus randomized traffic.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [4:0]         imm_op;
  logic               zero_ext;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  immediate;
  logic               imm_err;
  logic [CNT_W-1:0]   count;

  imm_extend_pipe #(
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .imm_op    (imm_op),
    .zero_ext  (zero_ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .immediate (immediate),
    .imm_err   (imm_err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en     = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;

`ifdef IMM_BRANCH_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic err);
    exp_t e;
    e.imm = imm;
    e.err = err;
    return e;
  endfunction

  // Reference: take the field as an integer, subtract 2^width if it is negative
  function automatic exp_t model(input logic [31:0] w, input logic [4:0] op, input logic zx);
    int unsigned     msb, lsb;
    bit              sext, branch;
    longint unsigned span, v;
    exp_t            e;
    e.imm = 64'd0;
    e.err = 1'b0;
    branch = 1'b0;
    sext   = !zx;
    case (op)
      5'b10000: begin msb = 25; lsb = 0;  branch = 1'b1; end
      5'b01000: begin msb = 23; lsb = 5;  branch = 1'b1; end
      5'b00100: begin msb = 21; lsb = 10; end
      5'b00010: begin msb = 15; lsb = 10; sext = 1'b0; end
      5'b00001: begin msb = 20; lsb = 12; end
      5'b00000: return e;
      default: begin e.err = 1'b1; return e; end
    endcase
    span = 64'd1 << (msb - lsb + 1);
    v    = (64'(w) >> lsb) % span;
    if (sext && (v >= span / 2)) v = v - span;
    if (branch && SCALE) v = v << 2;
    e.imm = v;
    return e;
  endfunction

  // Single owner of out_ready
  always @(negedge clk) begin
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: pops the scoreboard on every output handshake
  logic [63:0] prev_imm;
  logic        prev_err;
  bit          prev_hold = 1'b0;
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_imm", immediate, prev_imm);
        check("hold_err", 64'(imm_err), 64'(prev_err));
      end
      if (!out_valid) begin
        check("empty_imm", immediate, 64'd0);
        check("empty_err", 64'(imm_err), 64'd0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%016h, required no output", immediate);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_imm", immediate, e.imm);
          check("out_err", 64'(imm_err), 64'(e.err));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_imm  = immediate;
      prev_err  = imm_err;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w, input logic [4:0] op, input logic zx, input exp_t e);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    instr    = w;
    imm_op   = op;
    zero_ext = zx;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, required 1 within 100 cycles");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [4:0] ops [7];
    ops[0] = 5'b10000; ops[1] = 5'b01000; ops[2] = 5'b00100; ops[3] = 5'b00010;
    ops[4] = 5'b00001; ops[5] = 5'b00000; ops[6] = 5'b11111;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    imm_op   = '0;
    zero_ext = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm", immediate, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2 check("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // Directed field vectors
    send(32'h0200_0001, 5'b10000, 1'b0,
         mk(SCALE ? 64'hFFFF_FFFF_F800_0004 : 64'hFFFF_FFFF_FE00_0001, 1'b0));
    send(32'h0080_0020, 5'b01000, 1'b0,
         mk(SCALE ? 64'hFFFF_FFFF_FFF0_0004 : 64'hFFFF_FFFF_FFFC_0001, 1'b0));
    send(32'h0020_0400, 5'b00100, 1'b0, mk(64'hFFFF_FFFF_FFFF_F801, 1'b0));
    send(32'h0020_0400, 5'b00100, 1'b1, mk(64'h0000_0000_0000_0801, 1'b0));
    send(32'h0000_8400, 5'b00010, 1'b0, mk(64'h21, 1'b0));
    send(32'h0010_1000, 5'b00001, 1'b0, mk(64'hFFFF_FFFF_FFFF_FF01, 1'b0));
    send(32'hFFFF_FFFF, 5'b00000, 1'b0, mk(64'h0, 1'b0));
    send(32'hFFFF_FFFF, 5'b00011, 1'b0, mk(64'h0, 1'b1));
    wait_drain();

    // Backpressure: two fill the buffer, the third waits
    ready_force = 1'b0;
    @(negedge clk);
    send(32'h0000_0400, 5'b00100, 1'b0, mk(64'h1, 1'b0));
    send(32'h0000_0800, 5'b00100, 1'b0, mk(64'h2, 1'b0));
    fork
      send(32'h0000_0C00, 5'b00100, 1'b0, mk(64'h3, 1'b0));
      begin
        repeat (3) @(negedge clk);
        #2;
        check("bp_count", 64'(count), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        ready_force = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with two entries buffered
    ready_force = 1'b0;
    @(negedge clk);
    send(32'h0000_0400, 5'b00100, 1'b0, mk(64'h1, 1'b0));
    send(32'h0000_0800, 5'b00100, 1'b0, mk(64'h2, 1'b0));
    @(negedge clk);
    #2 check("pre_rst_count", 64'(count), 64'd2);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_imm", immediate, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    #2 check("arst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      logic [4:0]  op;
      logic        zx;
      w  = $urandom;
      op = ops[$urandom_range(0, 6)];
      if (op == 5'b11111) op = 5'($urandom);
      zx = 1'($urandom_range(0, 1));
      send(w, op, zx, model(w, op, zx));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-002 SHALL have parameter DATA_W, default 64, immediate width; legal range 32..64.
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  producer presents instr/imm_op/zero_ext.
REQ-007 SHALL have port in_ready  output  1  block accepts this cycle.
REQ-008 SHALL have port instr  input  INSTR_W  instruction word.
REQ-009 SHALL have port imm_op  input  5  one-hot format select: B=10000, CB=01000, I=00100, Shift=00010, D=00001, NONE=00000.
REQ-010 SHALL have port zero_ext  input  1  zero-extend instead of sign-extend for I/D/CB/B.
REQ-011 SHALL have port out_valid  output  1  head entry valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port immediate  output  DATA_W  head entry immediate.
REQ-014 SHALL have port imm_err  output  1  head entry had illegal imm_op.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-016 SHALL extract fields: B instr[25:0], CB instr[23:5], I instr[21:10], Shift instr[15:10], D instr[20:12].
REQ-017 SHALL sign-extend the field MSB to DATA_W unless zero_ext=1; Shift is always zero-extended.
REQ-018 SHALL produce immediate 0, imm_err 0 for NONE.
REQ-019 SHALL produce immediate 0, imm_err 1 for any imm_op not one-hot and not zero.
REQ-020 SHALL accept an input on a rising clk edge with in_valid & in_ready, and write the result into the buffer tail.
REQ-021 SHALL drive in_ready = (count < DEPTH); no combinational path from out_ready to in_ready.
REQ-022 SHALL raise out_valid the cycle after the first accepted input; minimum latency one cycle, no input-to-output bypass.
REQ-023 SHALL pop the head on out_valid & out_ready and preserve FIFO order.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and the new entry queued behind.
REQ-025 SHALL drive out_valid = (count != 0), immediate 0 and imm_err 0 when empty.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL hold head outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, on rst_n low at any time (including mid-transfer), asynchronously clear count, pointers, out_valid, immediate and imm_err to 0 and discard buffered entries.
REQ-029 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL, with IMM_BRANCH_SCALE_EN defined, shift B and CB immediates left by 2 after extension, truncating to DATA_W.
REQ-031 SHALL, without IMM_BRANCH_SCALE_EN, output B and CB immediates unscaled; other formats are unaffected either way.

Structure
REQ-032 SHALL place in package imm_pkg: the imm_op one-hot encodings as a typedef, the field bit positions as constants, and the DATA_W default.
REQ-033 SHALL implement extraction and extension combinationally in sub-module imm_field_extract; the buffer and handshake logic stay in imm_extend_pipe.

Verification
REQ-034 SHALL cover B, instr[25]=1, instr[0]=1, scale off -> 0xFFFFFFFFFE000001; scale on -> 0xFFFFFFFFF8000004.
REQ-035 SHALL cover CB, instr[23]=1, instr[5]=1 -> 0xFFFFFFFFFFFC0001; I, instr[21]=1, instr[10]=1 -> 0xFFFFFFFFFFFFF801, and with zero_ext=1 -> 0x0000000000000801.
REQ-036 SHALL cover Shift, instr[15]=1, instr[10]=1 -> 0x21; D, instr[20]=1, instr[12]=1 -> 0xFFFFFFFFFFFFFF01; NONE -> 0.
REQ-037 SHALL cover out_ready=0 with three pushes -> count=2, in_ready=0, third held; then out_ready=1 -> all three drain in order.
REQ-038 SHALL cover imm_op=00011 -> imm_err=1, immediate=0; rst_n pulse with count=2 -> count=0, out_valid=0 immediately.
